// File: rtl/station_writer_if.sv
// station_writer_if: pWQE stream, station slot status, dpsram port 0, slot set request and statistics
interface station_writer_if #(
  parameter int PWQE_BUF_ADDR_WIDTH  = 2,
  parameter int PWQE_BUF_WIDTH       = 512,
  parameter int PWQE_SLOT_NUM        = 4,
  parameter int PWQE_SLOT_ADDR_WIDTH = 2,
  parameter int CNT_WIDTH            = 16
) ();
  logic                            i_wqe_valid;
  logic                            o_wqe_ready;
  logic [PWQE_BUF_WIDTH-1:0]       i_wqe_data;
  logic [PWQE_SLOT_NUM-1:0]        i_slot_status;
  logic                            o_ren_0;
  logic                            o_wen_0;
  logic [PWQE_BUF_ADDR_WIDTH-1:0]  o_addr_0;
  logic [PWQE_BUF_WIDTH-1:0]       o_din_0;
  logic                            o_set_req;
  logic [PWQE_SLOT_ADDR_WIDTH-1:0] o_set_addr;
  logic [CNT_WIDTH-1:0]            o_wqe_cnt;
  logic [CNT_WIDTH-1:0]            o_stall_cnt;
  modport master (
    output i_wqe_valid, i_wqe_data, i_slot_status,
    input  o_wqe_ready, o_ren_0, o_wen_0, o_addr_0, o_din_0, o_set_req, o_set_addr, o_wqe_cnt, o_stall_cnt
  );
  modport slave (
    input  i_wqe_valid, i_wqe_data, i_slot_status,
    output o_wqe_ready, o_ren_0, o_wen_0, o_addr_0, o_din_0, o_set_req, o_set_addr, o_wqe_cnt, o_stall_cnt
  );
endinterface

// File: rtl/station_writer.sv
// station_writer: writes accepted pWQEs into the lowest free station slot; STATION_WRITER_STALL_CNT_EN adds the full-station stall counter
module station_writer #(
  parameter int PWQE_BUF_ADDR_WIDTH  = 2,
  parameter int PWQE_BUF_WIDTH       = 512,
  parameter int PWQE_SLOT_NUM        = 4,
  parameter int PWQE_SLOT_ADDR_WIDTH = 2,
  parameter int CNT_WIDTH            = 16
) (
  input logic clk,
  input logic rst_n,
  station_writer_if.slave bus
);
  typedef enum logic [1:0] {INIT, IDLE, COMMIT, SETTLE} state_t;
  state_t state, state_nxt;
  logic [PWQE_SLOT_ADDR_WIDTH-1:0] free_idx;
  logic ready, accept, commit_nxt;
  assign ready = state == IDLE && |(~bus.i_slot_status);
  assign bus.o_wqe_ready = ready;
  assign bus.o_ren_0 = 1'b0;
  // fixed-priority free slot pick, index 0 wins
  always_comb begin
    free_idx = '0;
    for (int i = PWQE_SLOT_NUM - 1; i >= 0; i--)
      if (!bus.i_slot_status[i]) free_idx = PWQE_SLOT_ADDR_WIDTH'(i);
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= INIT;
    else state <= state_nxt;
  // next state: one accept, then a commit cycle and a settle cycle for the status to catch up
  always_comb
    state_nxt = state == INIT ? IDLE :
                state == IDLE ? (accept ? COMMIT : IDLE) :
                state == COMMIT ? SETTLE : IDLE;
  // output decode feeding the registered port-0 and set-request outputs
  always_comb begin
    accept = bus.i_wqe_valid && ready;
    commit_nxt = state_nxt == COMMIT;
  end
  // capture the pWQE and slot on accept; strobe write and set during COMMIT only
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.o_wen_0 <= 1'b0;
      bus.o_set_req <= 1'b0;
      bus.o_addr_0 <= '0;
      bus.o_set_addr <= '0;
      bus.o_din_0 <= {PWQE_BUF_WIDTH{1'b0}};
      bus.o_wqe_cnt <= '0;
    end else begin
      bus.o_wen_0 <= commit_nxt;
      bus.o_set_req <= commit_nxt;
      if (accept) begin
        bus.o_addr_0 <= PWQE_BUF_ADDR_WIDTH'(free_idx);
        bus.o_set_addr <= free_idx;
        bus.o_din_0 <= bus.i_wqe_data;
        bus.o_wqe_cnt <= bus.o_wqe_cnt + CNT_WIDTH'(1);
      end
    end
`ifdef STATION_WRITER_STALL_CNT_EN
  // saturating count of idle cycles blocked by a full station
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) bus.o_stall_cnt <= '0;
    else if (state == IDLE && bus.i_wqe_valid && &bus.i_slot_status && !(&bus.o_stall_cnt))
      bus.o_stall_cnt <= bus.o_stall_cnt + CNT_WIDTH'(1);
`else
  assign bus.o_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_station_writer.sv
// tb_station_writer: scoreboard-driven checks of slot selection, commit timing, stall, reset and counter wrap
module tb_station_writer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int last_acc = 0;
  typedef struct {
    logic [1:0]   slot;
    logic [511:0] data;
  } exp_t;
  exp_t sb[$];

  station_writer_if #(.CNT_WIDTH(16)) bus ();
  station_writer #(.CNT_WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  station_writer_if #(.CNT_WIDTH(4)) wbus ();
  station_writer #(.CNT_WIDTH(4)) wdut (.clk(clk), .rst_n(rst_n), .bus(wbus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lowest_free(input logic [3:0] s);
    for (int i = 0; i < 4; i++) if (!s[i]) return i;
    return -1;
  endfunction

  // present d until accepted, score the COMMIT cycle, optionally mark the slot occupied in SETTLE
  task automatic send(input logic [511:0] d, input bit track, output int slot);
    bit ok = 0;
    exp_t e;
    slot = -1;
    bus.i_wqe_valid = 1'b1;
    bus.i_wqe_data = d;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (bus.o_wqe_ready === 1'b1) ok = 1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout: ready never seen, required acceptance within 50 cycles");
      bus.i_wqe_valid = 1'b0;
      return;
    end
    slot = lowest_free(bus.i_slot_status);
    e.slot = slot[1:0];
    e.data = d;
    sb.push_back(e);
    @(posedge clk);
    #1;
    last_acc = cyc;
    bus.i_wqe_valid = 1'b0;
    bus.i_wqe_data = '1;
    @(negedge clk);
    e = sb.pop_front();
    if ({bus.o_wen_0, bus.o_set_req, bus.o_addr_0, bus.o_set_addr} !== {2'b11, e.slot, e.slot}) begin
      errors++;
      $display("FAIL commit_ctrl: wen/set/addr/set_addr=%b %b %0d %0d, required 1 1 %0d %0d",
               bus.o_wen_0, bus.o_set_req, bus.o_addr_0, bus.o_set_addr, e.slot, e.slot);
    end
    checks++;
    if (bus.o_din_0 !== e.data) begin
      errors++;
      $display("FAIL commit_din: got %h required %h", bus.o_din_0, e.data);
    end
    @(posedge clk);
    #1;
    if (track) bus.i_slot_status[slot] = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.o_wqe_ready, bus.o_ren_0, bus.o_wen_0, bus.o_set_req, bus.o_addr_0, bus.o_set_addr} !== 8'd0 ||
        bus.o_din_0 !== 512'd0 || bus.o_wqe_cnt !== 16'd0 || bus.o_stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_values: ready=%b wen=%b set=%b addr=%0d cnt=%0d stall=%0d, required all 0",
               bus.o_wqe_ready, bus.o_wen_0, bus.o_set_req, bus.o_addr_0, bus.o_wqe_cnt, bus.o_stall_cnt);
    end
  endtask

  task automatic test_single();
    int rel, slot;
    bus.i_slot_status = 4'b0000;
    bus.i_wqe_valid = 1'b1;
    bus.i_wqe_data = 512'hA5;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rel = cyc;
    @(negedge clk);
    checks++;
    if (bus.o_wqe_ready !== 1'b0) begin
      errors++;
      $display("FAIL init_ready: got %b required 0", bus.o_wqe_ready);
    end
    send(512'hA5, 1'b1, slot);
    checks++;
    if (last_acc - rel !== 2 || slot !== 0) begin
      errors++;
      $display("FAIL single_latency: accept %0d cycles after release in slot %0d, required 2 and slot 0", last_acc - rel, slot);
    end
    checks++;
    if (bus.o_wqe_cnt !== 16'd1) begin
      errors++;
      $display("FAIL single_cnt: got %0d required 1", bus.o_wqe_cnt);
    end
    @(negedge clk);
    checks++;
    if ({bus.o_wen_0, bus.o_set_req} !== 2'b00 || bus.o_din_0 !== 512'hA5) begin
      errors++;
      $display("FAIL settle_hold: wen=%b set=%b din=%h, required 0 0 a5", bus.o_wen_0, bus.o_set_req, bus.o_din_0);
    end
  endtask

  task automatic test_lowest_free();
    int slot;
    bus.i_slot_status = 4'b1011;
    send(512'h1234_5678, 1'b0, slot);
    checks++;
    if (slot !== 2) begin
      errors++;
      $display("FAIL lowest_free: slot %0d required 2", slot);
    end
  endtask

  task automatic test_full_stall();
    int t0, slot;
    @(posedge clk);
    #1;
    bus.i_slot_status = 4'b1111;
    bus.i_wqe_valid = 1'b1;
    bus.i_wqe_data = 512'hDEAD;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.o_wqe_ready, bus.o_wen_0, bus.o_set_req} !== 3'b000) begin
        errors++;
        $display("FAIL full_stall cycle %0d: ready/wen/set=%b%b%b required 000", k, bus.o_wqe_ready, bus.o_wen_0, bus.o_set_req);
      end
      bus.i_wqe_data = 512'(k + 100);
    end
    @(posedge clk);
    #1;
    checks++;
`ifdef STATION_WRITER_STALL_CNT_EN
    if (bus.o_stall_cnt !== 16'd10) begin
      errors++;
      $display("FAIL stall_cnt: got %0d required 10", bus.o_stall_cnt);
    end
`else
    if (bus.o_stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL stall_cnt: got %0d required 0", bus.o_stall_cnt);
    end
`endif
    bus.i_slot_status = 4'b1101;
    t0 = cyc;
    send(512'hBEEF, 1'b0, slot);
    checks++;
    if (last_acc - t0 !== 1 || slot !== 1) begin
      errors++;
      $display("FAIL stall_release: accept after %0d cycles in slot %0d, required 1 and slot 1", last_acc - t0, slot);
    end
  endtask

  task automatic test_back_to_back();
    int slot, prev, c0;
    logic [511:0] d;
    c0 = int'(bus.o_wqe_cnt);
    bus.i_slot_status = 4'b0000;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      d = {480'd0, 32'hD000_0000 + 32'(k)};
      send(d, 1'b1, slot);
      checks++;
      if (slot !== k || (k > 0 && last_acc - prev !== 3)) begin
        errors++;
        $display("FAIL b2b_%0d: slot %0d spacing %0d, required slot %0d spacing 3", k, slot, last_acc - prev, k);
      end
      prev = last_acc;
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (int'(bus.o_wqe_cnt) !== c0 + 4 || bus.o_wqe_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: cnt=%0d ready=%b, required cnt=%0d ready=0", bus.o_wqe_cnt, bus.o_wqe_ready, c0 + 4);
    end
  endtask

  task automatic test_mid_reset();
    bit ok = 0;
    bus.i_slot_status = 4'b0000;
    bus.i_wqe_valid = 1'b1;
    bus.i_wqe_data = 512'hCAFE;
    for (int k = 0; k < 10 && !ok; k++) begin
      @(negedge clk);
      if (bus.o_wqe_ready === 1'b1) ok = 1;
    end
    @(posedge clk);
    #1;
    bus.i_wqe_valid = 1'b0;
    checks++;
    if (!ok || bus.o_wen_0 !== 1'b1) begin
      errors++;
      $display("FAIL mid_commit: ready_seen=%b wen=%b, required 1 1", ok, bus.o_wen_0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.o_wen_0, bus.o_set_req} !== 2'b00 || bus.o_wqe_cnt !== 16'd0) begin
      errors++;
      $display("FAIL async_reset: wen=%b set=%b cnt=%0d, required 0 0 0", bus.o_wen_0, bus.o_set_req, bus.o_wqe_cnt);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.o_wqe_ready !== 1'b0 || bus.o_wqe_cnt !== 16'd0) begin
      errors++;
      $display("FAIL post_reset_init: ready=%b cnt=%0d, required 0 0", bus.o_wqe_ready, bus.o_wqe_cnt);
    end
    @(negedge clk);
    checks++;
    if (bus.o_wqe_ready !== 1'b1 || bus.o_wen_0 !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: ready=%b wen=%b, required 1 0", bus.o_wqe_ready, bus.o_wen_0);
    end
  endtask

  task automatic test_wrap();
    int n = 0;
    wbus.i_slot_status = 4'b0000;
    @(posedge clk);
    #1;
    wbus.i_wqe_valid = 1'b1;
    for (int k = 0; k < 200 && n < 17; k++) begin
      @(negedge clk);
      if (wbus.o_wqe_ready === 1'b1) begin
        n++;
        if (n == 16) begin
          @(posedge clk);
          #1;
          checks++;
          if (wbus.o_wqe_cnt !== 4'd0) begin
            errors++;
            $display("FAIL wrap_16: cnt=%0d required 0", wbus.o_wqe_cnt);
          end
        end
        if (n == 17) begin
          @(posedge clk);
          #1;
          wbus.i_wqe_valid = 1'b0;
        end
      end
      wbus.i_wqe_data = 512'(n);
    end
    @(negedge clk);
    checks++;
    if (n !== 17 || wbus.o_wqe_cnt !== 4'd1) begin
      errors++;
      $display("FAIL wrap_17: accepted %0d cnt=%0d, required 17 and cnt=1", n, wbus.o_wqe_cnt);
    end
  endtask

  initial begin
    bus.i_wqe_valid = 1'b0;
    bus.i_wqe_data = '0;
    bus.i_slot_status = '0;
    wbus.i_wqe_valid = 1'b0;
    wbus.i_wqe_data = '0;
    wbus.i_slot_status = '0;
    test_reset();
    test_single();
    test_lowest_free();
    test_full_stall();
    test_back_to_back();
    test_mid_reset();
    test_wrap();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
